enemy_fire_arbiter: RTL
=======================

ENEMY_FIRE_ARBITER -- requirements
Module: enemy_fire_arbiter

Interface
REQ-001 SHALL have parameters: COOLDOWN_BASE, default 50000000, base cycles between enemy shots; COOLDOWN_STEP, default 4000000, cycles removed per level; COOLDOWN_MIN, default 10000000, cooldown floor.
REQ-002 SHALL have ports: pclk input 1 (peripheral clock, single clock domain); rst input 1 (asynchronous, active-high reset).
REQ-003 SHALL have ports: req input 5, per-enemy fire request, bit i = enemy i+1; alive input 5, enemy i+1 still alive; level input 4, current level; level_up input 1, level-transition hold active; missile_busy input 1, shared enemy missile in flight.
REQ-004 SHALL have ports: grant output 5, one-hot shooter select; fire output 1, launch strobe for shared missile; enemy_id output 3, shooter number 1..5, 0 when idle.

Function
REQ-005 SHALL implement states COOLDOWN, ARB, FIRE in a 2-bit state register; all outputs registered.
REQ-006 SHALL compute limit = max(COOLDOWN_BASE - level*COOLDOWN_STEP, COOLDOWN_MIN) in 32-bit unsigned arithmetic, saturating to COOLDOWN_MIN instead of underflowing.
REQ-007 COOLDOWN: 32-bit counter +1 per cycle; when counter >= limit, clear counter, go to ARB.
REQ-008 ARB: eligible = req AND alive; if missile_busy=1 or eligible=0, remain in ARB, no output change.
REQ-009 ARB with missile_busy=0 and eligible≠0: select first eligible index searching from pointer upward, wrapping 4->0; go to FIRE.
REQ-010 FIRE lasts exactly one cycle: fire=1, grant=one-hot winner, enemy_id=winner+1; then COOLDOWN with counter 0.
REQ-011 Outside FIRE: fire=0, grant=0, enemy_id=0.
REQ-012 Latency: eligible request and missile_busy=0 sampled in ARB cycle N -> fire=1 in cycle N+1.
REQ-013 After a grant to index i, pointer SHALL become (i+1) mod 5; pointer unchanged otherwise.
REQ-014 level_up=1 in COOLDOWN or ARB: force COOLDOWN, counter 0, every cycle while asserted.
REQ-015 level_up=1 during FIRE: pulse completes unchanged; next state COOLDOWN, counter 0.
REQ-016 missile_busy rising in the same cycle as ARB decision: no grant that cycle.
REQ-017 req bit set with alive bit clear SHALL never be granted.
REQ-018 level change mid-COOLDOWN: new limit applies immediately; counter already >= new limit exits next cycle.

Reset
REQ-019 rst=1 asynchronously SHALL force: state COOLDOWN, counter 0, pointer 0, grant 0, fire 0, enemy_id 0.
REQ-020 After rst release, first possible fire SHALL occur no earlier than limit+2 cycles.
REQ-021 rst asserted during FIRE SHALL clear fire in the same cycle, without waiting for a clock edge.

Configuration
REQ-022 Macro FIRE_RANDOM_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11, reset seed 16'hACE1) SHALL advance every cycle, rst included; ARB search start = lfsr[2:0] mod 5 instead of pointer.
REQ-023 FIRE_RANDOM_EN undefined: no LFSR logic; round-robin start = pointer per REQ-013.

Verification (COOLDOWN_BASE=20, COOLDOWN_STEP=4, COOLDOWN_MIN=8, FIRE_RANDOM_EN undefined)
REQ-024 level=1, req=alive=5'b11111, busy=0, rst released -> fire pulses with enemy_id 1,2,3,4,5,1, one per 18 cycles (16 cooldown+ARB+FIRE).
REQ-025 level=5 -> limit 8 (saturated; 20-20=0 clamped); level=2 -> limit 12; fire spacing 10 and 14 cycles respectively.
REQ-026 req=5'b10100, alive=5'b00100 -> only enemy_id=3 ever granted; alive=0 -> fire never asserts, state parks in ARB.
REQ-027 missile_busy=1 held 50 cycles at ARB -> no fire; busy falls at cycle T -> fire=1 at T+1, grant=5'b00001.
REQ-028 level_up=1 for 30 cycles mid-cooldown -> counter held 0, no fire; after release fire no earlier than limit+2 cycles.
REQ-029 rst asserted asynchronously during FIRE -> fire, grant, enemy_id drop to 0 before the next pclk edge; pointer returns to 0.

Source files
------------

// File: rtl/enemy_fire_arbiter.sv
// Purpose: picks one live enemy per cooldown period to fire the single shared missile. The pick is round-robin, or LFSR-started when FIRE_RANDOM_EN is defined.
// Latency: fire comes one cycle after an eligible request is sampled in ARB. The cooldown lasts limit cycles, where limit = max(BASE - level*STEP, MIN).
// Backpressure: while missile_busy is high the arbiter stays in ARB and grants nothing. level_up holds the cooldown counter at zero.
module enemy_fire_arbiter #(
   parameter logic [31:0] COOLDOWN_BASE = 32'd50000000,
   parameter logic [31:0] COOLDOWN_STEP = 32'd4000000,
   parameter logic [31:0] COOLDOWN_MIN  = 32'd10000000
) (
   input  logic       pclk,
   input  logic       rst,
   input  logic [4:0] req,
   input  logic [4:0] alive,
   input  logic [3:0] level,
   input  logic       level_up,
   input  logic       missile_busy,
   output logic [4:0] grant,
   output logic       fire,
   output logic [2:0] enemy_id
);

   typedef enum logic [1:0] {
      COOLDOWN = 2'd0,
      ARB      = 2'd1,
      FIRE     = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [2:0]  ptr_q, ptr_d;
   logic [4:0]  grant_q, grant_d;
   logic        fire_q, fire_d;
   logic [2:0]  id_q, id_d;

   logic [35:0] step_total;
   logic [31:0] diff;
   logic [31:0] limit;
   logic [31:0] cnt_inc;
   logic [4:0]  eligible;
   logic [2:0]  start;
   logic [2:0]  win;
   logic        found;
   logic [3:0]  idx;

   assign eligible = req & alive;
   assign cnt_inc  = cnt_q + 32'd1;

   // Cooldown limit follows the level combinationally.
   // The product is computed wide, so a large level clamps to the floor instead of wrapping.
   always_comb begin
      step_total = 36'(level) * 36'(COOLDOWN_STEP);
      diff       = 32'd0;
      if (step_total < 36'(COOLDOWN_BASE)) begin
         diff = COOLDOWN_BASE - step_total[31:0];
      end
      limit = (diff < COOLDOWN_MIN) ? COOLDOWN_MIN : diff;
   end

`ifdef FIRE_RANDOM_EN
   logic [15:0] lfsr_q;
   logic        lfsr_fb;

   assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

   // Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) that supplies the search start.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= {lfsr_q[14:0], lfsr_fb};
      end
   end

   assign start = (lfsr_q[2:0] >= 3'd5) ? (lfsr_q[2:0] - 3'd5) : lfsr_q[2:0];
`else
   assign start = ptr_q;
`endif

   // Take the first eligible enemy, searching upward from start and wrapping from 4 to 0.
   always_comb begin
      win   = 3'd0;
      found = 1'b0;
      idx   = 4'd0;
      for (int k = 0; k < 5; k++) begin
         idx = {1'b0, start} + 4'(k);
         if (idx >= 4'd5) begin
            idx = idx - 4'd5;
         end
         if (!found && eligible[idx[2:0]]) begin
            win   = idx[2:0];
            found = 1'b1;
         end
      end
   end

   // Next-state logic. The registered outputs are decided here, one cycle ahead of the FIRE state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      fire_d  = 1'b0;
      grant_d = 5'b00000;
      id_d    = 3'd0;
      case (state_q)
         COOLDOWN: begin
            if (level_up) begin
               cnt_d = 32'd0;
            end else if (cnt_inc >= limit) begin
               cnt_d   = 32'd0;
               state_d = ARB;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ARB: begin
            if (level_up) begin
               cnt_d   = 32'd0;
               state_d = COOLDOWN;
            end else if (!missile_busy && found) begin
               state_d = FIRE;
               fire_d  = 1'b1;
               grant_d = 5'b00001 << win;
               id_d    = win + 3'd1;
               ptr_d   = (win == 3'd4) ? 3'd0 : (win + 3'd1);
            end
         end
         FIRE: begin
            // The pulse always completes. A concurrent level_up simply lands in a fresh cooldown.
            cnt_d   = 32'd0;
            state_d = COOLDOWN;
         end
         default: begin
            cnt_d   = 32'd0;
            state_d = COOLDOWN;
         end
      endcase
   end

   // State, counter, pointer and output registers. Reset clears the outputs immediately.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state_q <= COOLDOWN;
         cnt_q   <= 32'd0;
         ptr_q   <= 3'd0;
         grant_q <= 5'b00000;
         fire_q  <= 1'b0;
         id_q    <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         fire_q  <= fire_d;
         id_q    <= id_d;
      end
   end

   assign grant    = grant_q;
   assign fire     = fire_q;
   assign enemy_id = id_q;

endmodule
